// File: rtl/decoder_proj_stable_pkg.sv
// Shared types and the decode helper for the filtered pad decoder.
// decode() works on the widest supported code; callers cast down to their own width.
package decoder_proj_pkg;

    localparam int MAX_CODE_W = 8;
    localparam int MAX_OUT_W  = 2 ** MAX_CODE_W;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_INV    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_COMMIT = 2'b10
    } state_e;

    // Hold mode never reaches here in practice; it yields zero so the caller decides.
    function automatic logic [MAX_OUT_W-1:0] decode(input logic [MAX_CODE_W-1:0] code,
                                                    input mode_e mode);
        logic [MAX_OUT_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            case (mode)
                MODE_ONEHOT: res[i] = (i == int'(code));
                MODE_THERM:  res[i] = (i <= int'(code));
                MODE_INV:    res[i] = (i != int'(code));
                default:     res[i] = 1'b0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_proj_stable_if.sv
// Pad-side bus of the filtered decoder: code/control in, decoded results out.
interface decoder_proj_stable_if #(
    parameter int CODE_W = 4,
    parameter int CNT_W  = 8
);
    localparam int OUT_W = 2 ** CODE_W;

    logic [CODE_W-1:0] io_in;
    logic              en;
    logic [1:0]        mode;
    logic [OUT_W-1:0]  dec_out;
    logic [CODE_W-1:0] dec_code;
    logic              dec_valid;
    logic [CNT_W-1:0]  evt_cnt;
    logic              busy;

    modport master (
        output io_in, en, mode,
        input  dec_out, dec_code, dec_valid, evt_cnt, busy
    );

    modport slave (
        input  io_in, en, mode,
        output dec_out, dec_code, dec_valid, evt_cnt, busy
    );

endinterface

// File: rtl/decoder_proj_sync.sv
// Multi-stage flop chain bringing the asynchronous pad code into the wb_clk_i domain.
module decoder_proj_sync #(
    parameter int CODE_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [CODE_W-1:0] async_i,
    output logic [CODE_W-1:0] sync_o
);

    logic [CODE_W-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/decoder_proj_stable.sv
// Filtered pad decoder: a code is accepted only after STABLE_CYC identical synced samples,
// then decoded into a registered vector and counted with a saturating counter.
module decoder_proj_stable
    import decoder_proj_pkg::*;
#(
    parameter int CODE_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    decoder_proj_stable_if.slave  bus
);

    localparam int OUT_W    = 2 ** CODE_W;
    localparam int CNT_BITS = $clog2(STABLE_CYC);

    logic [CODE_W-1:0]   sync;
    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0]   cand_q, cand_d;
    logic [CODE_W-1:0]   dec_code_q, dec_code_d;
    logic [OUT_W-1:0]    dec_out_q, dec_out_d;
    logic                dec_valid_q, dec_valid_d;
    logic [CNT_W-1:0]    evt_cnt_q, evt_cnt_d;
    mode_e               mode;
    logic                holdMode;

    decoder_proj_sync #(
        .CODE_W      (CODE_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .async_i  (bus.io_in),
        .sync_o   (sync)
    );

    assign mode     = mode_e'(bus.mode);
    assign holdMode = (mode == MODE_HOLD);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            dec_code_q  <= '0;
            dec_out_q   <= '0;
            dec_valid_q <= 1'b0;
            evt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            dec_code_q  <= dec_code_d;
            dec_out_q   <= dec_out_d;
            dec_valid_q <= dec_valid_d;
            evt_cnt_q   <= evt_cnt_d;
        end
    end

    // Outside COMMIT the output tracks the committed code in the current mode,
    // so a mode change alone shows up one cycle later without a valid pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        dec_code_d  = dec_code_q;
        dec_valid_d = 1'b0;
        evt_cnt_d   = evt_cnt_q;
        dec_out_d   = holdMode ? dec_out_q
                               : OUT_W'(decode(MAX_CODE_W'(dec_code_q), mode));

        case (state_q)
            ST_IDLE: begin
                if (bus.en && !holdMode && (sync != dec_code_q)) begin
                    state_d = ST_SETTLE;
                    cand_d  = sync;
                    cnt_d   = CNT_BITS'(1);
                end
            end
            ST_SETTLE: begin
                if (!bus.en || holdMode) begin
                    state_d = ST_IDLE;
                end else if (sync == dec_code_q) begin
                    state_d = ST_IDLE;
                end else if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = CNT_BITS'(1);
                end else if (cnt_q == CNT_BITS'(STABLE_CYC - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            // Commit completes even if hold mode arrives now; hold then just freezes dec_out.
            ST_COMMIT: begin
                dec_code_d  = cand_q;
                dec_out_d   = holdMode ? dec_out_q
                                       : OUT_W'(decode(MAX_CODE_W'(cand_q), mode));
                dec_valid_d = 1'b1;
                evt_cnt_d   = (&evt_cnt_q) ? evt_cnt_q : evt_cnt_q + CNT_W'(1);
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.dec_out   = dec_out_q;
    assign bus.dec_code  = dec_code_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.evt_cnt   = evt_cnt_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_decoder_proj_stable.sv
// Bench for decoder_proj_stable: a wide-counter and a 2-bit-counter instance share stimulus,
// and expectations come from an arithmetic model of the acceptance/decode rules.
module tb_decoder_proj_stable;

    logic       clk;
    logic       rstIn;
    logic [3:0] ioIn;
    logic       enIn;
    logic [1:0] modeIn;

    int testsRun;
    int testsFailed;

    logic [3:0] expCode;
    int         expCount;

    decoder_proj_stable_if #(.CODE_W(4), .CNT_W(8)) ifc ();
    decoder_proj_stable_if #(.CODE_W(4), .CNT_W(2)) ifcSat ();

    assign ifc.io_in    = ioIn;
    assign ifc.en       = enIn;
    assign ifc.mode     = modeIn;
    assign ifcSat.io_in = ioIn;
    assign ifcSat.en    = enIn;
    assign ifcSat.mode  = modeIn;

    decoder_proj_stable #(
        .CODE_W(4), .SYNC_STAGES(2), .STABLE_CYC(4), .CNT_W(8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rstIn),
        .bus      (ifc)
    );

    decoder_proj_stable #(
        .CODE_W(4), .SYNC_STAGES(2), .STABLE_CYC(4), .CNT_W(2)
    ) dutSat (
        .wb_clk_i (clk),
        .wb_rst_i (rstIn),
        .bus      (ifcSat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoded vector by plain arithmetic: one-hot, thermometer, inverted one-hot.
    function automatic logic [15:0] refDecode(input logic [3:0] code, input logic [1:0] m);
        logic [31:0] one;
        logic [31:0] v;
        one = 32'd1;
        case (m)
            2'b00:   v = one << code;
            2'b01:   v = (one << (code + 32'd1)) - one;
            2'b10:   v = ~(one << code);
            default: v = 32'd0;
        endcase
        return v[15:0];
    endfunction

    function automatic logic [31:0] satCount(input int n);
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    function automatic logic [3:0] otherCode(input logic [3:0] avoid);
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        if (c == avoid) c = c + 4'd1;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code, input logic en, input logic [1:0] m);
        ioIn   = code;
        enIn   = en;
        modeIn = m;
    endtask

    // Hold a new code from an idle, settled state; pulse expected after the 7th edge.
    task automatic acceptCode(input logic [3:0] code, input logic [1:0] m);
        applyStimulus(code, 1'b1, m);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkOutput("noEarlyPulse", 32'(ifc.dec_valid), 32'd0);
            if (k == 1) checkOutput("preOut", 32'(ifc.dec_out), 32'(refDecode(expCode, m)));
            if (k == 2) checkOutput("idleBusy", 32'(ifc.busy), 32'd0);
            if (k == 4) checkOutput("settleBusy", 32'(ifc.busy), 32'd1);
        end
        tick();
        expCode = code;
        expCount++;
        checkOutput("acceptValid", 32'(ifc.dec_valid), 32'd1);
        checkOutput("acceptCode", 32'(ifc.dec_code), 32'(expCode));
        checkOutput("acceptOut", 32'(ifc.dec_out), 32'(refDecode(expCode, m)));
        checkOutput("acceptCnt", 32'(ifc.evt_cnt), 32'(expCount));
        checkOutput("acceptCntSat", 32'(ifcSat.evt_cnt), satCount(expCount));
        tick();
        checkOutput("pulseOneCycle", 32'(ifc.dec_valid), 32'd0);
        checkOutput("busyAfter", 32'(ifc.busy), 32'd0);
    endtask

    // A code present for fewer than four synced cycles must never be accepted.
    task automatic glitchCode(input logic [3:0] code, input int len);
        ioIn = code;
        for (int k = 0; k < len; k++) begin
            tick();
            checkOutput("glitchNoPulseA", 32'(ifc.dec_valid), 32'd0);
        end
        ioIn = expCode;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("glitchNoPulseB", 32'(ifc.dec_valid), 32'd0);
        end
        checkOutput("glitchBusy", 32'(ifc.busy), 32'd0);
        checkOutput("glitchCnt", 32'(ifc.evt_cnt), 32'(expCount));
        checkOutput("glitchCode", 32'(ifc.dec_code), 32'(expCode));
        checkOutput("glitchOut", 32'(ifc.dec_out), 32'(refDecode(expCode, modeIn)));
    endtask

    task automatic switchMode(input logic [1:0] m);
        modeIn = m;
        tick();
        checkOutput("modeSwitchOut", 32'(ifc.dec_out), 32'(refDecode(expCode, m)));
        checkOutput("modeSwitchNoPulse", 32'(ifc.dec_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] frozen;
        logic [3:0]  code;
        int          n;

        testsRun    = 0;
        testsFailed = 0;
        expCode     = 4'd0;
        expCount    = 0;

        // Reset with io_in = 0
        rstIn = 1'b1;
        applyStimulus(4'd0, 1'b1, 2'b00);
        tick(); tick(); tick();
        checkOutput("rstOut", 32'(ifc.dec_out), 32'd0);
        checkOutput("rstCode", 32'(ifc.dec_code), 32'd0);
        checkOutput("rstValid", 32'(ifc.dec_valid), 32'd0);
        checkOutput("rstCnt", 32'(ifc.evt_cnt), 32'd0);
        checkOutput("rstBusy", 32'(ifc.busy), 32'd0);
        rstIn = 1'b0;
        tick();
        checkOutput("postRstOut", 32'(ifc.dec_out), 32'(refDecode(4'd0, 2'b00)));

        // Glitch of two cycles against code 0, then basic acceptance of 5
        glitchCode(4'd5, 2);
        acceptCode(4'd5, 2'b00);
        checkOutput("basicOutConst", 32'(ifc.dec_out), 32'h0020);

        // Thermometer, then switch to inverted
        acceptCode(4'd3, 2'b01);
        checkOutput("thermConst", 32'(ifc.dec_out), 32'h000F);
        switchMode(2'b10);
        checkOutput("invConst", 32'(ifc.dec_out), 32'hFFF7);

        // Hold mode freezes dec_out and blocks acceptance
        frozen = ifc.dec_out;
        applyStimulus(4'd9, 1'b1, 2'b11);
        n = $urandom_range(3, 8);
        for (int k = 0; k < n; k++) begin
            tick();
            checkOutput("holdNoPulse", 32'(ifc.dec_valid), 32'd0);
        end
        checkOutput("holdOut", 32'(ifc.dec_out), 32'(frozen));
        checkOutput("holdBusy", 32'(ifc.busy), 32'd0);
        modeIn = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("holdReleaseNoPulse", 32'(ifc.dec_valid), 32'd0);
        end
        tick();
        expCode = 4'd9;
        expCount++;
        checkOutput("holdReleaseValid", 32'(ifc.dec_valid), 32'd1);
        checkOutput("holdReleaseOut", 32'(ifc.dec_out), 32'h0200);
        checkOutput("holdReleaseCntSat", 32'(ifcSat.evt_cnt), satCount(expCount));
        tick();

        // Disabled filter ignores a changed code
        applyStimulus(otherCode(expCode), 1'b0, 2'b00);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("disabledNoPulse", 32'(ifc.dec_valid), 32'd0);
        end
        checkOutput("disabledBusy", 32'(ifc.busy), 32'd0);
        ioIn = expCode;
        tick(); tick(); tick();
        enIn = 1'b1;
        tick();
        checkOutput("reenableBusy", 32'(ifc.busy), 32'd0);

        // Randomised mix of acceptances, glitches and mode switches
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0: acceptCode(otherCode(expCode), 2'($urandom_range(0, 2)));
                1: glitchCode(otherCode(expCode), $urandom_range(1, 3));
                default: switchMode(2'($urandom_range(0, 2)));
            endcase
        end
        acceptCode(otherCode(expCode), 2'($urandom_range(0, 2)));
        acceptCode(otherCode(expCode), 2'($urandom_range(0, 2)));
        checkOutput("satHeld", 32'(ifcSat.evt_cnt), 32'd3);

        // Reset on the second SETTLE cycle
        code = otherCode(expCode);
        modeIn = 2'b00;
        ioIn = code;
        tick(); tick(); tick();
        checkOutput("midSettleBusy", 32'(ifc.busy), 32'd1);
        tick();
        rstIn = 1'b1;
        ioIn  = 4'd0;
        tick();
        expCode  = 4'd0;
        expCount = 0;
        checkOutput("midRstOut", 32'(ifc.dec_out), 32'd0);
        checkOutput("midRstCode", 32'(ifc.dec_code), 32'd0);
        checkOutput("midRstValid", 32'(ifc.dec_valid), 32'd0);
        checkOutput("midRstCnt", 32'(ifc.evt_cnt), 32'd0);
        checkOutput("midRstCntSat", 32'(ifcSat.evt_cnt), 32'd0);
        checkOutput("midRstBusy", 32'(ifc.busy), 32'd0);
        rstIn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("postMidRstNoPulse", 32'(ifc.dec_valid), 32'd0);
        end
        checkOutput("postMidRstOut", 32'(ifc.dec_out), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
